ddr3_wb_width_bridge: RTL



---
 rtl/ddr3_wb_width_bridge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ddr3_wb_width_bridge.sv
// 32-bit pipelined Wishbone to 128-bit DDR3 controller port bridge; one transaction at a time.
// Define READ_BUF_EN to add a single-line write-through read buffer.
module ddr3_wb_width_bridge #(
  parameter int DN_ADDR_BITS = 25,
  parameter int DN_DATA_BITS = 128
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      up_cyc_i,
  input  logic                      up_stb_i,
  input  logic                      up_we_i,
  input  logic [DN_ADDR_BITS+1:0]   up_addr_i,
  input  logic [3:0]                up_sel_i,
  input  logic [31:0]               up_dat_i,
  output logic                      up_stall_o,
  output logic                      up_ack_o,
  output logic [31:0]               up_dat_o,
  output logic                      dn_cyc_o,
  output logic                      dn_stb_o,
  output logic                      dn_we_o,
  output logic [DN_ADDR_BITS-1:0]   dn_addr_o,
  output logic [15:0]               dn_sel_o,
  output logic [DN_DATA_BITS-1:0]   dn_dat_o,
  input  logic                      dn_stall_i,
  input  logic                      dn_ack_i,
  input  logic [DN_DATA_BITS-1:0]   dn_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    next_state_s;
  logic                      accept_s;
  logic                      done_s;
  logic                      hit_s;
  logic [31:0]               hit_dat_s;
  logic [1:0]                lane_r;
  logic [DN_ADDR_BITS-1:0]   req_line_s;
  logic [15:0]               req_sel_s;

  function automatic logic [31:0] lane_slice(input logic [127:0] line, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_slice = line[31:0];
      2'd1:    lane_slice = line[63:32];
      2'd2:    lane_slice = line[95:64];
      2'd3:    lane_slice = line[127:96];
      default: lane_slice = 32'h0000_0000;
    endcase
  endfunction

  assign req_line_s = up_addr_i[DN_ADDR_BITS+1:2];
  // Reads fetch the whole line so the buffer (when present) can be filled from it.
  assign req_sel_s  = up_we_i ? ({12'h000, up_sel_i} << {up_addr_i[1:0], 2'b00}) : 16'hFFFF;
  assign up_stall_o = (state_r != ST_IDLE);

`ifdef READ_BUF_EN
  logic [127:0]              buf_data_r;
  logic [DN_ADDR_BITS-1:0]   buf_tag_r;
  logic                      buf_valid_r;

  function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                               input logic [127:0] new_line,
                                               input logic [15:0]  sel);
    for (int b = 0; b < 16; b++) begin
      merge_bytes[8*b +: 8] = sel[b] ? new_line[8*b +: 8] : old_line[8*b +: 8];
    end
  endfunction

  assign hit_s     = !up_we_i && buf_valid_r && (buf_tag_r == req_line_s);
  assign hit_dat_s = lane_slice(buf_data_r, up_addr_i[1:0]);

  // Line buffer: filled by read misses, patched by write-through to the buffered line.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_data_r  <= 128'h0;
      buf_tag_r   <= '0;
      buf_valid_r <= 1'b0;
    end else if (done_s) begin
      if (!dn_we_o) begin
        buf_data_r  <= dn_dat_i;
        buf_tag_r   <= dn_addr_o;
        buf_valid_r <= 1'b1;
      end else if (buf_valid_r && (buf_tag_r == dn_addr_o)) begin
        buf_data_r  <= merge_bytes(buf_data_r, dn_dat_o, dn_sel_o);
      end
    end
  end
`else
  assign hit_s     = 1'b0;
  assign hit_dat_s = 32'h0000_0000;
`endif

  // Next-state logic; an upstream abort takes priority over a coincident downstream ack.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (up_cyc_i && up_stb_i) begin
          accept_s     = 1'b1;
          next_state_s = hit_s ? ST_RESP : ST_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!up_cyc_i) begin
          next_state_s = ST_IDLE;
        end else if (!dn_stall_i) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (!up_cyc_i) begin
          next_state_s = ST_IDLE;
        end else if (dn_ack_i) begin
          done_s       = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and bus strobes, registered from the next state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= ST_IDLE;
      dn_cyc_o <= 1'b0;
      dn_stb_o <= 1'b0;
      up_ack_o <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      dn_cyc_o <= (next_state_s == ST_REQ) || (next_state_s == ST_WAIT);
      dn_stb_o <= (next_state_s == ST_REQ);
      up_ack_o <= (next_state_s == ST_RESP);
    end
  end

  // Request latch and read-data return; downstream fields only change on a new downstream request.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lane_r    <= 2'd0;
      dn_we_o   <= 1'b0;
      dn_addr_o <= '0;
      dn_sel_o  <= 16'h0000;
      dn_dat_o  <= '0;
      up_dat_o  <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        lane_r <= up_addr_i[1:0];
        if (hit_s) begin
          up_dat_o <= hit_dat_s;
        end else begin
          dn_we_o   <= up_we_i;
          dn_addr_o <= req_line_s;
          dn_sel_o  <= req_sel_s;
          dn_dat_o  <= {4{up_dat_i}};
        end
      end
      if (done_s && !dn_we_o) begin
        up_dat_o <= lane_slice(dn_dat_i, lane_r);
      end
    end
  end

endmodule
